// File: rtl/free_list_ss.sv
// free_list_ss: superscalar, checkpointable physical-register free list.
// Circular buffer; head is restored from a branch checkpoint on mispredict.
module free_list_ss #(
  parameter int NUM_PHYS_REG = 64,
  parameter int NUM_GEN_REG  = 32,
  parameter int DISP_WIDTH   = 2,
  parameter int RET_WIDTH    = 2,
  localparam int PR_W  = $clog2(NUM_PHYS_REG),
  localparam int PTR_W = PR_W + 1,
  localparam int CNT_W = PR_W + 1,
  localparam int DN_W  = $clog2(DISP_WIDTH + 1)
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic [DN_W-1:0]           dispatch_num,
  input  logic [RET_WIDTH-1:0]      retire_en,
  input  logic [RET_WIDTH*PR_W-1:0] T_old,
  input  logic                      branch_incorrect,
  input  logic [PTR_W-1:0]          head_check_point,
  output logic [DISP_WIDTH*PR_W-1:0] free_reg,
  output logic [DISP_WIDTH-1:0]     free_valid,
  output logic                      alloc_stall,
  output logic [PTR_W-1:0]          head_out,
  output logic [CNT_W-1:0]          num_free_entries,
  output logic                      empty,
  output logic                      overflow_err
);

  logic [PR_W-1:0]  list_q [NUM_PHYS_REG];
  logic [PTR_W-1:0] head_q, head_d;
  logic [PTR_W-1:0] tail_q, tail_d;
  logic             ovf_q, ovf_d;

  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] space;
  logic [CNT_W-1:0] nwr;
  logic [CNT_W-1:0] req;
  logic [RET_WIDTH-1:0] wr_en;
  logic [PR_W-1:0]  wr_idx [RET_WIDTH];

  assign cnt   = tail_q - head_q;
  assign space = CNT_W'(NUM_PHYS_REG) - cnt;
  assign req   = CNT_W'(dispatch_num);

  // Compact valid retire slots onto the tail; drop what does not fit.
  always_comb begin
    nwr   = '0;
    wr_en = '0;
    ovf_d = ovf_q;
    for (int s = 0; s < RET_WIDTH; s++) begin
      wr_idx[s] = tail_q[PR_W-1:0] + nwr[PR_W-1:0];
      if (retire_en[s]) begin
        if (nwr < space) begin
          wr_en[s] = 1'b1;
          nwr      = nwr + CNT_W'(1);
        end else begin
          ovf_d = 1'b1;
        end
      end
    end
    tail_d = tail_q + nwr;
  end

  always_comb begin
    alloc_stall = !branch_incorrect && (req > cnt);
    head_d      = head_q;
    if (branch_incorrect)
      head_d = head_check_point;
    else if (!alloc_stall)
      head_d = head_q + req;
  end

  always_comb begin
    free_reg   = '0;
    free_valid = '0;
    for (int i = 0; i < DISP_WIDTH; i++) begin
      free_reg[i*PR_W +: PR_W] = list_q[head_q[PR_W-1:0] + PR_W'(i)];
      free_valid[i]            = CNT_W'(i) < cnt;
    end
  end

  assign head_out         = head_q;
  assign num_free_entries = cnt;
  assign empty            = (cnt == '0);
  assign overflow_err     = ovf_q;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NUM_PHYS_REG; i++) begin
        if (i < NUM_PHYS_REG - NUM_GEN_REG)
          list_q[i] <= PR_W'(NUM_GEN_REG + i);
        else
          list_q[i] <= '0;
      end
      head_q <= '0;
      tail_q <= PTR_W'(NUM_PHYS_REG - NUM_GEN_REG);
      ovf_q  <= 1'b0;
    end else begin
      for (int s = 0; s < RET_WIDTH; s++) begin
        if (wr_en[s])
          list_q[wr_idx[s]] <= T_old[s*PR_W +: PR_W];
      end
      head_q <= head_d;
      tail_q <= tail_d;
      ovf_q  <= ovf_d;
    end
  end

endmodule

// File: tb/tb_free_list_ss.sv
// tb_free_list_ss: scoreboard bench for free_list_ss.
// Model tracks an unbounded sequence of list positions in an assoc array.
module tb_free_list_ss;

  logic        clock = 1'b0;
  logic        reset;
  logic [1:0]  dispatch_num;
  logic [1:0]  retire_en;
  logic [11:0] T_old;
  logic        branch_incorrect;
  logic [6:0]  head_check_point;
  logic [11:0] free_reg;
  logic [1:0]  free_valid;
  logic        alloc_stall;
  logic [6:0]  head_out;
  logic [6:0]  num_free_entries;
  logic        empty;
  logic        overflow_err;

  free_list_ss dut (
    .clock            (clock),
    .reset            (reset),
    .dispatch_num     (dispatch_num),
    .retire_en        (retire_en),
    .T_old            (T_old),
    .branch_incorrect (branch_incorrect),
    .head_check_point (head_check_point),
    .free_reg         (free_reg),
    .free_valid       (free_valid),
    .alloc_stall      (alloc_stall),
    .head_out         (head_out),
    .num_free_entries (num_free_entries),
    .empty            (empty),
    .overflow_err     (overflow_err)
  );

  always #5 clock = ~clock;

  typedef struct packed {
    logic [5:0] fr1;
    logic [5:0] fr0;
    logic [1:0] fv;
    logic       st;
    logic [6:0] ho;
    logic [6:0] cnt;
    logic       emp;
    logic       ovf;
  } exp_t;

  exp_t expq[$];
  int   slot[int];
  int   hd, tl;
  bit   m_ovf;
  int   hist[$];
  int   total  = 0;
  int   passed = 0;

  function automatic void chk(string nm, int act, int exp);
    total++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
  endfunction

  function automatic void model_reset();
    slot.delete();
    for (int k = 0; k < 32; k++) slot[k] = 32 + k;
    hd    = 0;
    tl    = 32;
    m_ovf = 1'b0;
    hist.delete();
  endfunction

  task automatic step(input int dn, input logic [1:0] ren, input int t0,
                      input int t1, input bit bi, input int ck);
    exp_t e;
    int   cnt, room;
    @(negedge clock);
    dispatch_num     = 2'(dn);
    retire_en        = ren;
    T_old            = {6'(t1), 6'(t0)};
    branch_incorrect = bi;
    head_check_point = 7'(ck % 128);
    cnt   = tl - hd;
    e     = '0;
    e.fv  = {cnt > 1, cnt > 0};
    if (cnt > 0) e.fr0 = 6'(slot[hd]);
    if (cnt > 1) e.fr1 = 6'(slot[hd+1]);
    e.st  = !bi && (dn > cnt);
    e.ho  = 7'(hd % 128);
    e.cnt = 7'(cnt);
    e.emp = (cnt == 0);
    e.ovf = m_ovf;
    #1 expq.push_back(e);
    room = 64 - cnt;
    if (ren[0]) begin
      if (room > 0) begin slot[tl] = t0; tl++; room--; end
      else m_ovf = 1'b1;
    end
    if (ren[1]) begin
      if (room > 0) begin slot[tl] = t1; tl++; room--; end
      else m_ovf = 1'b1;
    end
    hist.push_back(hd);
    if (hist.size() > 24) void'(hist.pop_front());
    if (bi) hd = ck;
    else if (dn <= cnt) hd += dn;
  endtask

  task automatic rand_step();
    int dn, pc, ck;
    int cand[$];
    logic [1:0] ren;
    bit bi;
    dn = $urandom_range(2);
    if (tl - hd > 58)
      ren = ($urandom_range(7) == 0) ? 2'($urandom_range(3)) : 2'b00;
    else
      ren = 2'($urandom_range(3));
    pc = int'(ren[0]) + int'(ren[1]);
    bi = 1'b0;
    ck = 0;
    if ($urandom_range(9) == 0) begin
      foreach (hist[k])
        if (hist[k] <= hd && tl + pc - hist[k] <= 64) cand.push_back(hist[k]);
      if (cand.size() > 0) begin
        bi = 1'b1;
        ck = cand[$urandom_range(cand.size() - 1)];
      end
    end
    step(dn, ren, $urandom_range(63), $urandom_range(63), bi, ck);
  endtask

  initial begin
    exp_t m;
    forever begin
      @(negedge clock);
      #2;
      if (expq.size() > 0) begin
        m = expq.pop_front();
        chk("alloc_stall", int'(alloc_stall), int'(m.st));
        chk("head_out", int'(head_out), int'(m.ho));
        chk("num_free", int'(num_free_entries), int'(m.cnt));
        chk("empty", int'(empty), int'(m.emp));
        chk("overflow_err", int'(overflow_err), int'(m.ovf));
        chk("free_valid", int'(free_valid), int'(m.fv));
        if (m.fv[0]) chk("free_reg0", int'(free_reg[5:0]), int'(m.fr0));
        if (m.fv[1]) chk("free_reg1", int'(free_reg[11:6]), int'(m.fr1));
      end
    end
  end

  initial begin
    int h;
    reset            = 1'b0;
    dispatch_num     = '0;
    retire_en        = '0;
    T_old            = '0;
    branch_incorrect = 1'b0;
    head_check_point = '0;
    model_reset();
    repeat (2) @(negedge clock);
    reset = 1'b1;

    step(2, 2'b00, 0, 0, 0, 0);
    step(0, 2'b00, 0, 0, 0, 0);

    repeat (14) step(2, 2'b00, 0, 0, 0, 0);
    step(1, 2'b00, 0, 0, 0, 0);
    step(2, 2'b00, 0, 0, 0, 0);
    step(1, 2'b00, 0, 0, 0, 0);

    step(1, 2'b10, 0, 5, 0, 0);
    step(0, 2'b00, 0, 0, 0, 0);

    repeat (6) step(0, 2'b11, $urandom_range(63), $urandom_range(63), 0, 0);
    h = hd;
    repeat (3) step(2, 2'b00, 0, 0, 0, 0);
    step(0, 2'b11, 7, 9, 1, h);
    repeat (8) step(2, 2'b00, 0, 0, 0, 0);

    while (tl - hd < 31) step(0, 2'b11, $urandom_range(63), $urandom_range(63), 0, 0);
    if (tl - hd < 32) step(0, 2'b01, $urandom_range(63), 0, 0, 0);
    repeat (40) step(1, 2'b01, $urandom_range(63), 0, 0, 0);

    while (tl - hd < 63) step(0, 2'b11, $urandom_range(63), $urandom_range(63), 0, 0);
    if (tl - hd < 64) step(0, 2'b01, $urandom_range(63), 0, 0, 0);
    step(0, 2'b01, 11, 0, 0, 0);
    step(0, 2'b00, 0, 0, 0, 0);
    repeat (3) step(2, 2'b00, 0, 0, 0, 0);

    repeat (400) rand_step();

    @(negedge clock);
    #3 reset = 1'b0;
    model_reset();
    @(negedge clock);
    reset = 1'b1;
    step(2, 2'b00, 0, 0, 0, 0);
    repeat (150) rand_step();

    repeat (2) @(negedge clock);
    #3;
    chk("queue_drained", expq.size(), 0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
